// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scan-code prefixes, queued entry layout and the frame parity check.
`timescale 1ns/1ps

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Entry layout: {ext, brk, code[7:0]}
    localparam int ENTRY_W = 10;
    typedef logic [ENTRY_W-1:0] ps2_entry_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic parityOk(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Input conditioning for the PS/2 lines: two-flop synchronizers, a glitch
// filter on the keyboard clock and a single-cycle strobe on each filtered
// falling edge, with the data line captured alongside it.
`timescale 1ns/1ps

module ps2_input_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2Clk_i,
    input  logic ps2Data_i,
    output logic fall_o,
    output logic data_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]       clkSync_q;
    logic [1:0]       dataSync_q;
    logic             filtClk_q;
    logic [CNT_W-1:0] filtCnt_q;
    logic             fall_q;
    logic             data_q;

    // Synchronize both lines, then accept a new clock level only after it persists.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            filtClk_q  <= 1'b1;
            filtCnt_q  <= '0;
            fall_q     <= 1'b0;
            data_q     <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2Clk_i};
            dataSync_q <= {dataSync_q[0], ps2Data_i};
            fall_q     <= 1'b0;
            if (clkSync_q[1] == filtClk_q) begin
                filtCnt_q <= '0;
            end else if (filtCnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filtClk_q <= clkSync_q[1];
                filtCnt_q <= '0;
                if (!clkSync_q[1]) begin
                    fall_q <= 1'b1;
                    data_q <= dataSync_q[1];
                end
            end else begin
                filtCnt_q <= filtCnt_q + CNT_W'(1);
            end
        end
    end

    assign fall_o = fall_q;
    assign data_o = data_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: decodes 11-bit frames, folds E0/F0 prefixes into
// flags on the following code and queues {ext, brk, code} entries in a small
// FIFO with a valid/ready interface to the consumer.
`timescale 1ns/1ps

module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       inCLK_50MHZ,
    input  logic       BTN_NORTH,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] code_out,
    output logic       break_out,
    output logic       ext_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic fall;
    logic fallData;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_i     (inCLK_50MHZ),
        .rst_i     (BTN_NORTH),
        .ps2Clk_i  (PS2_CLK),
        .ps2Data_i (PS2_DATA),
        .fall_o    (fall),
        .data_o    (fallData)
    );

    ps2_state_t      state_q;
    logic [2:0]      bitCnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [TO_W-1:0] timeCnt_q;
    logic            extPend_q;
    logic            brkPend_q;
    logic            frameErr_q;

    ps2_entry_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic stopStrobe;
    logic frameGood;
    logic isPrefix;
    logic timeoutHit;
    logic pushEn;
    logic popEn;
    logic fifoFull;
    logic pushOk;

    // Frame-level decisions taken in the cycle of each fall strobe.
    always_comb begin
        stopStrobe = (state_q == ST_STOP) && fall;
        frameGood  = stopStrobe && parityOk(shift_q, parity_q) && fallData;
        isPrefix   = (shift_q == PREFIX_EXT) || (shift_q == PREFIX_BRK);
        timeoutHit = (state_q != ST_IDLE) && !fall &&
                     (timeCnt_q == TO_W'(TIMEOUT_CYC - 1));
        pushEn     = frameGood && !isPrefix;
        popEn      = (count_q != '0) && code_ready;
        fifoFull   = (count_q == CNT_W'(FIFO_DEPTH));
        pushOk     = pushEn && (!fifoFull || popEn);
    end

    // Frame FSM: start, eight data bits LSB first, parity, stop, plus timeout.
    always_ff @(posedge inCLK_50MHZ) begin
        if (BTN_NORTH) begin
            state_q    <= ST_IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            timeCnt_q  <= '0;
            extPend_q  <= 1'b0;
            brkPend_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            if (state_q == ST_IDLE || fall) begin
                timeCnt_q <= '0;
            end else begin
                timeCnt_q <= timeCnt_q + TO_W'(1);
            end
            if (timeoutHit) begin
                state_q    <= ST_IDLE;
                timeCnt_q  <= '0;
                frameErr_q <= 1'b1;
                extPend_q  <= 1'b0;
                brkPend_q  <= 1'b0;
            end else if (fall) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!fallData) begin
                            state_q  <= ST_DATA;
                            bitCnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q  <= {fallData, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= fallData;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!frameGood) begin
                            frameErr_q <= 1'b1;
                            extPend_q  <= 1'b0;
                            brkPend_q  <= 1'b0;
                        end else if (shift_q == PREFIX_EXT) begin
                            extPend_q <= 1'b1;
                        end else if (shift_q == PREFIX_BRK) begin
                            brkPend_q <= 1'b1;
                        end else begin
                            extPend_q <= 1'b0;
                            brkPend_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by valid.
    always_ff @(posedge inCLK_50MHZ) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= {extPend_q, brkPend_q, shift_q};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge inCLK_50MHZ) begin
        if (BTN_NORTH) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (popEn) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end else if (pushEn) begin
                overflow_q <= 1'b1;
            end
            if (pushOk && !popEn) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!pushOk && popEn) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign code_valid = (count_q != '0);
    assign code_out   = code_valid ? mem_q[rdPtr_q][7:0] : 8'h00;
    assign break_out  = code_valid ? mem_q[rdPtr_q][8]   : 1'b0;
    assign ext_out    = code_valid ? mem_q[rdPtr_q][9]   : 1'b0;
    assign frame_err  = frameErr_q;
    assign overflow   = overflow_q;

endmodule
